decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered instruction-decode pipeline stage for the pipelined RV32/RV64 core.
- Sits between the fetch stage and the execute stage.
- Decodes one instruction per cycle into the existing control bundle: aluSrc, reginsel, branch, aluOp, immVal, dwe, memReg, regWr.
- Adds register indices, illegal-instruction detection, optional M-extension decode, a valid/ready handshake with a 2-entry skid buffer, and a pipeline flush.

Parameters:
- XLEN, 32: datapath width, 32 or 64. Sets the immVal width and the dwe width (XLEN/8).
- EN_MUL, 0: 1 decodes RV M-extension R-type ops (funct7 = 0000001); 0 flags them illegal.
- ALUOP_W, 5: aluOp width, fixed at 5. Layout is {mext, instr[30], funct3}.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming instructions this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction; registered.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute stage accepts the bundle.
- out_pc  out  XLEN  PC passed through.
- out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], instr[24:20], instr[11:7].
- out_aluSrc  out  2  bit0 = PC operand (AUIPC); bit1 = immediate operand (ITYPE/LOAD/STORE/AUIPC).
- out_reginsel  out  2  00 = alu, 11 = pc+4 (JAL/JALR), 10 = imm (LUI).
- out_branch  out  2  01 = conditional, 11 = JAL, 10 = JALR, 00 = none.
- out_aluOp  out  ALUOP_W  ALU operation.
- out_immVal  out  XLEN  sign-extended immediate.
- out_dwe  out  XLEN/8  store byte enables.
- out_memReg  out  1  load writeback.
- out_regWr  out  1  register write enable.
- out_illegal  out  1  instruction is illegal.

Behaviour:
- Decode: combinational from in_instr. The result is captured into the output register on accept; latency is 1 cycle from accept to out_valid.
- Opcodes: standard RV32I (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011). When XLEN=64, also OP-IMM-32 0011011 and OP-32 0111011.
- aluOp:
  - OP: {mext, instr[30], funct3}, where mext = EN_MUL & (funct7 == 0000001). When mext=1, bit3 = 0.
  - OP-IMM: {0, funct3 == 101 ? instr[30] : 0, funct3}.
  - BRANCH, by funct3[2:1]: 00 -> 01000; 10 -> 00010; 11 -> 00011; 01 -> illegal.
  - All other opcodes: 00000.
- dwe (STORE only):
  - SB = 0x1, SH = 0x3, SW = 0xF.
  - SD = 0xFF when XLEN=64.
  - Any other funct3 is illegal.
- Other control signals:
  - regWr = 0 for STORE, BRANCH and illegal instructions; 1 otherwise.
  - memReg = 1 only for LOAD.
- Illegal conditions:
  - instr[1:0] != 11.
  - Unknown opcode.
  - Bad store or branch funct3.
  - M-ext op with EN_MUL=0.
  - OP with funct7 not in {0000000, 0100000, M}.
- Illegal instruction output: out_illegal = 1, regWr = 0, dwe = 0, branch = 00, memReg = 0. PC and the register indices still propagate.
- Buffer: main register plus one skid register.
  - in_ready = skid empty, registered.
  - Output holds stable while out_valid & !out_ready.
  - An accept while main is full and stalled goes to the skid register.
  - When main drains, skid moves into main in the same edge.
  - Strict in-order delivery; no drop, no duplication.
- Simultaneous accept and drain: the new entry enters main directly, with no bubble. Full throughput is one instruction per cycle when out_ready = 1.
- flush:
  - Clears main and skid valid in the same edge; the incoming instruction is not captured.
  - in_ready = 1 the next cycle.
  - Flush has priority over all handshakes.
- Reset:
  - out_valid = 0, skid empty, in_ready = 1.
  - All data outputs = 0.
  - Reset mid-stall discards held entries.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle: out_valid=1, aluOp=0x00, regWr=1, aluSrc=00, rs1=1, rs2=2, rd=3, illegal=0.
- SRAI x5,x6,3 (0x40335293) -> aluOp=0x0D, immVal[4:0]=3, aluSrc=10. SW x2,8(x1) (0x0020A423) -> dwe=0xF, regWr=0, immVal=8.
- MUL x1,x2,x3 (0x023100B3): EN_MUL=1 -> aluOp=0x10, illegal=0. EN_MUL=0 -> illegal=1, regWr=0. Word 0x00000000 -> illegal=1.
- Backpressure: in_valid=1 streaming 4 instructions, out_ready=0 for 3 cycles -> in_ready drops after 2 accepts. On release, outputs come out in order with no loss or duplication and the bundle is stable while stalled.
- flush asserted with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1. The next accepted instruction appears alone.
- rst asserted mid-stall -> out_valid=0, all outputs 0, in_ready=1 the following cycle.

Source files
------------

// File: rtl/decode_stage.sv
// Registered RV32/RV64 instruction-decode stage with valid/ready handshake,
// a main output register plus one skid register, and a pipeline flush.
module decode_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned EN_MUL  = 0,
  parameter int unsigned ALUOP_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [1:0]          out_aluSrc,
  output logic [1:0]          out_reginsel,
  output logic [1:0]          out_branch,
  output logic [ALUOP_W-1:0]  out_aluOp,
  output logic [XLEN-1:0]     out_immVal,
  output logic [XLEN/8-1:0]   out_dwe,
  output logic                out_memReg,
  output logic                out_regWr,
  output logic                out_illegal
);

  localparam int unsigned DWE_W = XLEN / 8;
  localparam bit          RV64  = (XLEN == 64);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [1:0]         alusrc;
    logic [1:0]         reginsel;
    logic [1:0]         branch;
    logic [ALUOP_W-1:0] aluop;
    logic [XLEN-1:0]    imm;
    logic [DWE_W-1:0]   dwe;
    logic               memreg;
    logic               regwr;
    logic               illegal;
  } bundle_t;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};

  bundle_t dec;
  logic    bad;

  // Combinational decode of the incoming word into a control bundle.
  always_comb begin
    dec     = '0;
    bad     = 1'b0;
    dec.pc  = in_pc;
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.rd  = in_instr[11:7];
    case (opcode)
      OPC_LUI: begin
        dec.reginsel = 2'b10;
        dec.regwr    = 1'b1;
        dec.imm      = sext(imm_u);
      end
      OPC_AUIPC: begin
        dec.alusrc = 2'b11;
        dec.regwr  = 1'b1;
        dec.imm    = sext(imm_u);
      end
      OPC_JAL: begin
        dec.reginsel = 2'b11;
        dec.branch   = 2'b11;
        dec.regwr    = 1'b1;
        dec.imm      = sext(imm_j);
      end
      OPC_JALR: begin
        dec.reginsel = 2'b11;
        dec.branch   = 2'b10;
        dec.regwr    = 1'b1;
        dec.imm      = sext(imm_i);
      end
      OPC_BRANCH: begin
        dec.branch = 2'b01;
        dec.imm    = sext(imm_b);
        case (funct3[2:1])
          2'b00:   dec.aluop = ALUOP_W'(5'b01000);
          2'b10:   dec.aluop = ALUOP_W'(5'b00010);
          2'b11:   dec.aluop = ALUOP_W'(5'b00011);
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.alusrc = 2'b10;
        dec.memreg = 1'b1;
        dec.regwr  = 1'b1;
        dec.imm    = sext(imm_i);
      end
      OPC_STORE: begin
        dec.alusrc = 2'b10;
        dec.imm    = sext(imm_s);
        case (funct3)
          3'b000:  dec.dwe = DWE_W'(8'h01);
          3'b001:  dec.dwe = DWE_W'(8'h03);
          3'b010:  dec.dwe = DWE_W'(8'h0F);
          3'b011: begin
            if (RV64) dec.dwe = DWE_W'(8'hFF);
            else      bad     = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_IMM, OPC_IMM32: begin
        dec.alusrc = 2'b10;
        dec.regwr  = 1'b1;
        dec.imm    = sext(imm_i);
        dec.aluop  = ALUOP_W'({1'b0, (funct3 == 3'b101) & in_instr[30], funct3});
        if (opcode == OPC_IMM32 && !RV64) bad = 1'b1;
      end
      OPC_OP, OPC_OP32: begin
        dec.regwr = 1'b1;
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec.aluop = ALUOP_W'({1'b0, in_instr[30], funct3});
        end else if (funct7 == 7'b0000001) begin
          if (EN_MUL != 0) dec.aluop = ALUOP_W'({1'b1, 1'b0, funct3});
          else             bad       = 1'b1;
        end else begin
          bad = 1'b1;
        end
        if (opcode == OPC_OP32 && !RV64) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) bad = 1'b1;
    // An illegal word carries only its PC, register indices and the flag.
    if (bad) begin
      dec.alusrc   = '0;
      dec.reginsel = '0;
      dec.branch   = '0;
      dec.aluop    = '0;
      dec.imm      = '0;
      dec.dwe      = '0;
      dec.memreg   = 1'b0;
      dec.regwr    = 1'b0;
    end
    dec.illegal = bad;
  end

  bundle_t main_q, skid_q;
  logic    main_v, skid_v;
  logic    accept, drain;

  assign accept = in_valid & in_ready;
  assign drain  = main_v & out_ready;

  // Main/skid buffer: skid refills main on drain, new words bypass to main when free.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      in_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      in_ready <= 1'b1;
    end else if (!main_v || drain) begin
      if (skid_v) begin
        main_q   <= skid_q;
        main_v   <= 1'b1;
        skid_v   <= 1'b0;
        in_ready <= 1'b1;
      end else begin
        main_v <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_q   <= dec;
      skid_v   <= 1'b1;
      in_ready <= 1'b0;
    end
  end

  assign out_valid    = main_v;
  assign out_pc       = main_q.pc;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_rd       = main_q.rd;
  assign out_aluSrc   = main_q.alusrc;
  assign out_reginsel = main_q.reginsel;
  assign out_branch   = main_q.branch;
  assign out_aluOp    = main_q.aluop;
  assign out_immVal   = main_q.imm;
  assign out_dwe      = main_q.dwe;
  assign out_memReg   = main_q.memreg;
  assign out_regWr    = main_q.regwr;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (EN_MUL=0 and EN_MUL=1) share stimulus;
// a queue-based model predicts every cycle, plus directed literal checks.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        r0, v0, il0, mr0, rw0;
  logic [31:0] pc0, im0;
  logic [4:0]  s10, s20, d0, op0;
  logic [1:0]  as0, rs0, br0;
  logic [3:0]  we0;

  logic        r1, v1, il1, mr1, rw1;
  logic [31:0] pc1, im1;
  logic [4:0]  s11, s21, d1, op1;
  logic [1:0]  as1, rsl1, br1;
  logic [3:0]  we1;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .EN_MUL(0), .ALUOP_W(5)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r0),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(v0), .out_ready(out_ready),
    .out_pc(pc0), .out_rs1(s10), .out_rs2(s20), .out_rd(d0), .out_aluSrc(as0),
    .out_reginsel(rs0), .out_branch(br0), .out_aluOp(op0), .out_immVal(im0),
    .out_dwe(we0), .out_memReg(mr0), .out_regWr(rw0), .out_illegal(il0));

  decode_stage #(.XLEN(32), .EN_MUL(1), .ALUOP_W(5)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r1),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(v1), .out_ready(out_ready),
    .out_pc(pc1), .out_rs1(s11), .out_rs2(s21), .out_rd(d1), .out_aluSrc(as1),
    .out_reginsel(rsl1), .out_branch(br1), .out_aluOp(op1), .out_immVal(im1),
    .out_dwe(we1), .out_memReg(mr1), .out_regWr(rw1), .out_illegal(il1));

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
  endtask

  typedef struct packed {
    logic [1:0]  alusrc;
    logic [1:0]  reginsel;
    logic [1:0]  branch;
    logic [4:0]  aluop;
    logic [31:0] imm;
    logic [3:0]  dwe;
    logic        memreg;
    logic        regwr;
    logic        illegal;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  // Reference decode written opcode-by-opcode from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] i, input bit en_mul);
    exp_t        e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    bit          bad;
    e   = '0;
    f3  = i[14:12];
    f7  = i[31:25];
    bad = 1'b0;
    case (i[6:0])
      7'h37: begin e.reginsel = 2'd2; e.regwr = 1; e.imm = {i[31:12], 12'h000}; end
      7'h17: begin e.alusrc = 2'd3; e.regwr = 1; e.imm = {i[31:12], 12'h000}; end
      7'h6F: begin
        e.reginsel = 2'd3; e.branch = 2'd3; e.regwr = 1;
        e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      7'h67: begin
        e.reginsel = 2'd3; e.branch = 2'd2; e.regwr = 1;
        e.imm = 32'($signed(i[31:20]));
      end
      7'h63: begin
        e.branch = 2'd1;
        e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        if (f3 == 3'd0 || f3 == 3'd1)      e.aluop = 5'd8;
        else if (f3 == 3'd4 || f3 == 3'd5) e.aluop = 5'd2;
        else if (f3 == 3'd6 || f3 == 3'd7) e.aluop = 5'd3;
        else bad = 1;
      end
      7'h03: begin e.alusrc = 2'd2; e.memreg = 1; e.regwr = 1; e.imm = 32'($signed(i[31:20])); end
      7'h23: begin
        e.alusrc = 2'd2;
        e.imm = 32'($signed({i[31:25], i[11:7]}));
        if (f3 == 3'd0)      e.dwe = 4'b0001;
        else if (f3 == 3'd1) e.dwe = 4'b0011;
        else if (f3 == 3'd2) e.dwe = 4'b1111;
        else bad = 1;
      end
      7'h13: begin
        e.alusrc = 2'd2; e.regwr = 1; e.imm = 32'($signed(i[31:20]));
        e.aluop = 5'(f3) + ((f3 == 3'd5 && i[30]) ? 5'd8 : 5'd0);
      end
      7'h33: begin
        e.regwr = 1;
        if (f7 == 7'h00 || f7 == 7'h20) e.aluop = 5'(f3) + (i[30] ? 5'd8 : 5'd0);
        else if (f7 == 7'h01 && en_mul) e.aluop = 5'd16 + 5'(f3);
        else bad = 1;
      end
      default: bad = 1;
    endcase
    if (bad) e = '0;
    e.illegal = bad;
    return e;
  endfunction

  task automatic check_bundle(input string tag, input ent_t h, input exp_t e,
      input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [4:0] rd, input logic [1:0] asrc, input logic [1:0] rsel,
      input logic [1:0] br, input logic [4:0] aop, input logic [31:0] imm,
      input logic [3:0] dwe, input logic mreg, input logic rwr, input logic ill);
    chk({tag, ".pc"}, pc, h.pc);
    chk({tag, ".rs1"}, 32'(rs1), 32'(h.instr[19:15]));
    chk({tag, ".rs2"}, 32'(rs2), 32'(h.instr[24:20]));
    chk({tag, ".rd"}, 32'(rd), 32'(h.instr[11:7]));
    chk({tag, ".illegal"}, 32'(ill), 32'(e.illegal));
    chk({tag, ".regWr"}, 32'(rwr), 32'(e.regwr));
    chk({tag, ".dwe"}, 32'(dwe), 32'(e.dwe));
    chk({tag, ".branch"}, 32'(br), 32'(e.branch));
    chk({tag, ".memReg"}, 32'(mreg), 32'(e.memreg));
    if (!e.illegal) begin
      chk({tag, ".aluSrc"}, 32'(asrc), 32'(e.alusrc));
      chk({tag, ".reginsel"}, 32'(rsel), 32'(e.reginsel));
      chk({tag, ".aluOp"}, 32'(aop), 32'(e.aluop));
      chk({tag, ".immVal"}, imm, e.imm);
    end
  endtask

  ent_t q[$];
  bit   rst_seen = 1'b1;

  // Per-cycle compare against the queue model, then advance the model for the next edge.
  always @(negedge clk) begin
    ent_t h;
    ent_t n;
    bit   rdy;
    chk("in_ready0", 32'(r0), 32'(q.size() < 2));
    chk("in_ready1", 32'(r1), 32'(q.size() < 2));
    chk("out_valid0", 32'(v0), 32'(q.size() != 0));
    chk("out_valid1", 32'(v1), 32'(q.size() != 0));
    if (q.size() != 0) begin
      h = q[0];
      check_bundle("m0", h, model(h.instr, 1'b0), pc0, s10, s20, d0, as0, rs0, br0,
                   op0, im0, we0, mr0, rw0, il0);
      check_bundle("m1", h, model(h.instr, 1'b1), pc1, s11, s21, d1, as1, rsl1, br1,
                   op1, im1, we1, mr1, rw1, il1);
    end
    if (rst_seen) begin
      chk("rst_pc", pc0, 32'h0);
      chk("rst_imm", im0, 32'h0);
      chk("rst_ctl", 32'({as0, rs0, br0, op0, we0, mr0, rw0, il0, s10, s20, d0}), 32'h0);
    end
    rst_seen = rst;
    rdy = (q.size() < 2);
    if (rst || flush) q.delete();
    else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) begin
        n.instr = in_instr;
        n.pc    = in_pc;
        q.push_back(n);
      end
    end
  end

  logic [31:0] pc_r = 32'h0000_1000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc_r;
    pc_r     = pc_r + 32'd4;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] mix [0:17] = '{
    32'h123453B7, 32'hFFFFF217, 32'hFFDFF0EF, 32'h00008067, 32'h00208463,
    32'h0020C463, 32'h0020E463, 32'h0020A463, 32'hFFC12283, 32'h00208023,
    32'h00209023, 32'h0020B023, 32'h402081B3, 32'h042081B3, 32'h00004501,
    32'h0000001B, 32'hFFF00093, 32'h023150B3};
  logic [31:0] bp [0:3] = '{32'h002081B3, 32'h40335293, 32'h0020A423, 32'h023100B3};

  initial begin
    int   idx;
    logic acc;
    logic [31:0] dpc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) step();
    rst = 1'b0;
    chk("reset.out_valid", 32'(v0), 32'd0);
    chk("reset.in_ready", 32'(r0), 32'd1);
    chk("reset.immVal", im0, 32'd0);

    out_ready = 1'b1;
    send(32'h002081B3);
    chk("add.out_valid", 32'(v0), 32'd1);
    chk("add.aluOp", 32'(op0), 32'h00);
    chk("add.regWr", 32'(rw0), 32'd1);
    chk("add.aluSrc", 32'(as0), 32'd0);
    chk("add.rs", 32'({s10, s20, d0}), 32'({5'd1, 5'd2, 5'd3}));
    chk("add.illegal", 32'(il0), 32'd0);
    send(32'h40335293);
    chk("srai.aluOp", 32'(op0), 32'h0D);
    chk("srai.imm40", 32'(im0[4:0]), 32'd3);
    chk("srai.aluSrc", 32'(as0), 32'd2);
    send(32'h0020A423);
    chk("sw.dwe", 32'(we0), 32'hF);
    chk("sw.regWr", 32'(rw0), 32'd0);
    chk("sw.immVal", im0, 32'd8);
    send(32'h023100B3);
    chk("mul1.aluOp", 32'(op1), 32'h10);
    chk("mul1.illegal", 32'(il1), 32'd0);
    chk("mul0.illegal", 32'(il0), 32'd1);
    chk("mul0.regWr", 32'(rw0), 32'd0);
    send(32'h00000000);
    chk("zero.illegal", 32'(il0), 32'd1);

    for (int k = 0; k < 18; k++) send(mix[k]);
    step();

    // Backpressure: stall three cycles while streaming four words.
    idx = 0;
    dpc = pc_r;
    for (int c = 0; c < 12; c++) begin
      out_ready = (c >= 3);
      in_valid  = (idx < 4);
      in_instr  = bp[idx < 4 ? idx : 0];
      in_pc     = dpc + 32'(idx * 4);
      if (c == 2) chk("bp.in_ready", 32'(r0), 32'd0);
      acc = in_valid && r0;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    pc_r = dpc + 32'd16;
    chk("bp.accepted", 32'(idx), 32'd4);

    // Flush with both entries full and a word offered.
    out_ready = 1'b0;
    send(32'h00100093);
    send(32'h00200113);
    in_valid = 1'b1; in_instr = 32'h00300193; in_pc = pc_r; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.out_valid", 32'(v0), 32'd0);
    chk("flush.in_ready", 32'(r0), 32'd1);
    out_ready = 1'b1;
    dpc = pc_r;
    send(32'h00400213);
    chk("flush.next_pc", pc0, dpc);
    chk("flush.next_valid", 32'(v0), 32'd1);
    step();
    chk("flush.alone", 32'(v0), 32'd0);

    // Reset while stalled with two held words.
    out_ready = 1'b0;
    send(32'h00500293);
    send(32'h00600313);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2.out_valid", 32'(v0), 32'd0);
    chk("rst2.in_ready", 32'(r0), 32'd1);
    chk("rst2.pc", pc0, 32'd0);
    chk("rst2.regWr", 32'(rw0), 32'd0);
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
